// File: rtl/jtcps_obj_pkg.sv
// Shared constants and types for the CPS object line builder.
package jtcps_obj_pkg;

    localparam logic [1:0] WORD_X    = 2'd0;
    localparam logic [1:0] WORD_Y    = 2'd1;
    localparam logic [1:0] WORD_CODE = 2'd2;
    localparam logic [1:0] WORD_ATTR = 2'd3;

    localparam int unsigned ATTR_M_LSB = 12;
    localparam int unsigned ATTR_N_LSB = 8;
    localparam int unsigned ATTR_VFLIP = 6;
    localparam int unsigned ATTR_HFLIP = 5;

    localparam logic [1:0] SLOT_W0 = 2'd0;
    localparam logic [1:0] SLOT_W1 = 2'd1;
    localparam logic [1:0] SLOT_W2 = 2'd2;
    localparam logic [1:0] SLOT_W3 = 2'd3;

    localparam logic [15:0] FILL_WORD = 16'hFFFF;
    localparam logic [7:0]  END_CODE  = 8'hFF;

    typedef struct packed {
        logic [15:0] attr;
        logic [15:0] code;
        logic [15:0] y;
        logic [15:0] x;
    } obj_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_CHECK, ST_EMIT0, ST_EMIT1,
        ST_EMIT2, ST_EMIT3, ST_NEXT, ST_FILL
    } state_t;

endpackage

// File: rtl/jtcps_obj_tile_calc.sv
// Combinational per-tile math: zone test, vertical sub-row, tile code and x position.
module jtcps_obj_tile_calc
    import jtcps_obj_pkg::*;
(
    input  logic [9:0]  x,
    input  logic [8:0]  y,
    input  logic [15:0] attr,
    input  logic [15:0] code,
    input  logic [8:0]  vrender,
    input  logic [3:0]  col,
    input  logic [3:0]  code_mask,
    input  logic [3:0]  code_offset,
    output logic        inzone,
    output logic [3:0]  vsub,
    output logic [15:0] code_mn,
    output logic [9:0]  tile_x
);
    logic [8:0] diff;
    logic [3:0] m, n, row, row_adj, pos;
    logic       vflip, hflip;
    logic       unused_attr;

    assign m     = attr[ATTR_M_LSB +: 4];
    assign n     = attr[ATTR_N_LSB +: 4];
    assign vflip = attr[ATTR_VFLIP];
    assign hflip = attr[ATTR_HFLIP];
    assign unused_attr = ^{attr[7], attr[4:0]};

    // Wrapping distance from the object's top edge to the line being built
    assign diff    = vrender - y;
    assign inzone  = diff[8:4] <= {1'b0, m};
    assign row     = diff[7:4];
    assign vsub    = diff[3:0] ^ {4{vflip}};
    assign row_adj = vflip ? m - row : row;
    assign pos     = hflip ? n - col : col;

    assign code_mn = {(code[15:12] & code_mask) | code_offset, code[11:8],
                      4'(code[7:4] + row_adj), 4'(code[3:0] + col)};
    assign tile_x  = x + {2'b00, pos, 4'b0000};

endmodule

// File: rtl/jtcps_obj_line_builder.sv
// Builds the tile list of the next scanline into one half of a double-buffered
// line RAM while the renderer reads the other half.
module jtcps_obj_line_builder
    import jtcps_obj_pkg::*;
#(
    parameter int unsigned FRAME_AW = 10,
    parameter int unsigned LINE_AW  = 7,
    parameter logic [9:0]  XMIN     = 10'h030,
    parameter logic [9:0]  XMAX     = 10'h1C0,
    parameter bit          DUP_SKIP = 1'b1,
    parameter bit          END_MARK = 1'b1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [8:0]          vrender,
    input  logic                start,
    input  logic [3:0]          code_mask,
    input  logic [3:0]          code_offset,
    output logic [FRAME_AW-1:0] frame_addr,
    input  logic [15:0]         frame_data,
    input  logic [LINE_AW+1:0]  line_addr,
    output logic [15:0]         line_data,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [LINE_AW:0]    tile_cnt
);
    localparam int unsigned OBJ_AW    = FRAME_AW - 2;
    localparam int unsigned CNT_W     = LINE_AW + 1;
    localparam int unsigned RAM_AW    = LINE_AW + 3;
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

    state_t              state, state_nxt;
    obj_t                obj, last_obj;
    logic                have_last;
    logic [OBJ_AW-1:0]   obj_idx, obj_prev;
    logic [2:0]          wcnt;
    logic [1:0]          widx;
    logic [3:0]          col;
    logic [CNT_W-1:0]    wr_slot;
    logic [15:0]         ram [RAM_DEPTH];
    logic                ram_we;
    logic [1:0]          ram_word;
    logic [15:0]         ram_wdata;
    logic                inzone, clipped, is_dup, is_end, obj_last, last_col, slots_full;
    logic [3:0]          vsub;
    logic [15:0]         code_mn;
    logic [9:0]          tile_x;

    jtcps_obj_tile_calc u_calc (
        .x           (obj.x[9:0]),
        .y           (obj.y[8:0]),
        .attr        (obj.attr),
        .code        (obj.code),
        .vrender     (vrender),
        .col         (col),
        .code_mask   (code_mask),
        .code_offset (code_offset),
        .inzone      (inzone),
        .vsub        (vsub),
        .code_mn     (code_mn),
        .tile_x      (tile_x)
    );

    assign clipped    = (tile_x <= XMIN) || (tile_x >= XMAX);
    assign is_dup     = DUP_SKIP && have_last && (obj == last_obj);
    assign is_end     = END_MARK && (obj.attr[15:8] == END_CODE);
    assign obj_last   = obj_idx == '0;
    assign obj_prev   = obj_idx - OBJ_AW'(1);
    assign last_col   = col == obj.attr[ATTR_N_LSB +: 4];
    assign slots_full = wr_slot[LINE_AW];
    assign widx       = 2'(wcnt - 3'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and line RAM write port
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_word  = SLOT_W0;
        ram_wdata = FILL_WORD;
        case (state)
            ST_IDLE:  ;
            ST_FETCH: if (wcnt == 3'd4) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (is_end)                 state_nxt = ST_FILL;
                else if (!inzone || is_dup) state_nxt = obj_last ? ST_FILL : ST_FETCH;
                else                        state_nxt = ST_EMIT0;
            end
            ST_EMIT0: begin
                ram_we    = !clipped && !slots_full;
                ram_wdata = {4'd0, vsub, obj.attr[7:0]};
                state_nxt = (!clipped && slots_full) ? ST_IDLE : ST_EMIT1;
            end
            ST_EMIT1: begin
                ram_we    = !clipped;
                ram_word  = SLOT_W1;
                ram_wdata = code_mn;
                state_nxt = ST_EMIT2;
            end
            ST_EMIT2: begin
                ram_we    = !clipped;
                ram_word  = SLOT_W2;
                ram_wdata = {6'd0, tile_x};
                state_nxt = ST_EMIT3;
            end
            ST_EMIT3: begin
                ram_we    = !clipped;
                ram_word  = SLOT_W3;
                ram_wdata = 16'h0000;
                state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                if (!last_col)     state_nxt = ST_EMIT0;
                else if (obj_last) state_nxt = ST_FILL;
                else               state_nxt = ST_FETCH;
            end
            ST_FILL: begin
                ram_we   = !slots_full;
                ram_word = wcnt[1:0];
                if (slots_full) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (start) state_nxt = ST_FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_addr <= '1;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            tile_cnt   <= '0;
            wr_slot    <= '0;
            obj_idx    <= '1;
            wcnt       <= '0;
            col        <= '0;
            obj        <= '0;
            last_obj   <= '0;
            have_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy       <= 1'b1;
                overflow   <= 1'b0;
                tile_cnt   <= '0;
                wr_slot    <= '0;
                have_last  <= 1'b0;
                obj_idx    <= '1;
                wcnt       <= '0;
                frame_addr <= {{OBJ_AW{1'b1}}, WORD_X};
            end else begin
                case (state)
                    ST_FETCH: begin
                        // Read data trails the address by one cycle
                        wcnt <= wcnt + 3'd1;
                        if (wcnt < 3'd3) frame_addr <= frame_addr + FRAME_AW'(1);
                        if (wcnt != 3'd0) begin
                            case (widx)
                                WORD_X:    obj.x    <= frame_data;
                                WORD_Y:    obj.y    <= frame_data;
                                WORD_CODE: obj.code <= frame_data;
                                default:   obj.attr <= frame_data;
                            endcase
                        end
                    end
                    ST_CHECK: begin
                        wcnt <= '0;
                        col  <= '0;
                        if (state_nxt == ST_EMIT0) begin
                            last_obj  <= obj;
                            have_last <= 1'b1;
                        end
                    end
                    ST_EMIT0: if (!clipped && slots_full) overflow <= 1'b1;
                    ST_EMIT3: if (!clipped) begin
                        wr_slot  <= wr_slot + CNT_W'(1);
                        tile_cnt <= tile_cnt + CNT_W'(1);
                    end
                    ST_NEXT: if (!last_col) col <= col + 4'd1;
                    ST_FILL: if (!slots_full) begin
                        wcnt <= {1'b0, 2'(wcnt[1:0] + 2'd1)};
                        if (wcnt[1:0] == 2'd3) wr_slot <= wr_slot + CNT_W'(1);
                    end
                    default: ;
                endcase
                if (state_nxt == ST_FETCH && state != ST_FETCH) begin
                    obj_idx    <= obj_prev;
                    frame_addr <= {obj_prev, WORD_X};
                end
                if (state != ST_IDLE && state_nxt == ST_IDLE) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[{vrender[0], wr_slot[LINE_AW-1:0], ram_word}] <= ram_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) line_data <= '0;
        else     line_data <= ram[{~vrender[0], line_addr}];
    end

endmodule

// File: tb/tb_jtcps_obj_line_builder.sv
// Directed scoreboard bench for the object line builder.
module tb_jtcps_obj_line_builder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  vrender = 9'h055;
    logic        start = 1'b0;
    logic [3:0]  code_mask = 4'hF;
    logic [3:0]  code_offset = 4'h0;
    logic [9:0]  frame_addr, frame_addr_nd;
    logic [15:0] frame_data, frame_data_nd;
    logic [8:0]  line_addr = '0;
    logic [15:0] line_data, line_data_nd;
    logic        busy, done, overflow, busy_nd, done_nd, overflow_nd;
    logic [7:0]  tile_cnt, tile_cnt_nd;

    logic [15:0] fmem [1024];
    logic [15:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        frame_data    <= fmem[frame_addr];
        frame_data_nd <= fmem[frame_addr_nd];
    end

    jtcps_obj_line_builder dut (
        .clk(clk), .rst(rst), .vrender(vrender), .start(start),
        .code_mask(code_mask), .code_offset(code_offset),
        .frame_addr(frame_addr), .frame_data(frame_data),
        .line_addr(line_addr), .line_data(line_data),
        .busy(busy), .done(done), .overflow(overflow), .tile_cnt(tile_cnt)
    );

    jtcps_obj_line_builder #(.DUP_SKIP(1'b0)) dut_nd (
        .clk(clk), .rst(rst), .vrender(vrender), .start(start),
        .code_mask(code_mask), .code_offset(code_offset),
        .frame_addr(frame_addr_nd), .frame_data(frame_data_nd),
        .line_addr(line_addr), .line_data(line_data_nd),
        .busy(busy_nd), .done(done_nd), .overflow(overflow_nd), .tile_cnt(tile_cnt_nd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every object placed out of zone for line vr
    task automatic clear_frame(input logic [8:0] vr);
        logic [8:0] far_y;
        far_y = vr + 9'h100;
        for (int k = 0; k < 256; k++) begin
            fmem[4*k]   = 16'h0100;
            fmem[4*k+1] = {7'd0, far_y};
            fmem[4*k+2] = 16'h0000;
            fmem[4*k+3] = 16'h0000;
        end
    endtask

    task automatic set_obj(input int k, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] code, input logic [15:0] attr);
        fmem[4*k]   = x;
        fmem[4*k+1] = y;
        fmem[4*k+2] = code;
        fmem[4*k+3] = attr;
    endtask

    task automatic push_tile(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        exp_q.push_back(16'h0000);
    endtask

    task automatic push_fill();
        while (exp_q.size() < 512) exp_q.push_back(16'hFFFF);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit   seen;
        logic b;
        seen = 1'b0;
        b = 1'b1;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                b = busy;
            end
        end
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(b), 32'd0);
    endtask

    // Flip to the bank just written and drain the scoreboard against it
    task automatic check_line(input string tag);
        logic [15:0] e;
        vrender = vrender ^ 9'h001;
        @(negedge clk);
        line_addr = '0;
        for (int a = 0; a < 512; a++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk($sformatf("%s_w%0d", tag, a), 32'(line_data), 32'(e));
            line_addr = 9'(a + 1);
        end
        exp_q.delete();
    endtask

    initial begin
        clear_frame(9'h055);
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_tile_cnt", 32'(tile_cnt), 32'd0);
        chk("rst_frame_addr", 32'(frame_addr), 32'h3FF);
        chk("rst_line_data", 32'(line_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single tile
        vrender = 9'h055;
        clear_frame(vrender);
        set_obj(255, 16'h0100, 16'h0050, 16'h1230, 16'h0000);
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1");
        chk("t1_tile_cnt", 32'(tile_cnt), 32'd1);
        chk("t1_overflow", 32'(overflow), 32'd0);
        push_tile(16'h0500, 16'h1230, 16'h0100);
        push_fill();
        check_line("t1");

        // Multi-tile hflip object, vflip object, bank remap
        vrender = 9'h065;
        code_mask = 4'h3;
        code_offset = 4'h8;
        clear_frame(vrender);
        set_obj(255, 16'h0100, 16'h0050, 16'h1230, 16'h1220);
        set_obj(254, 16'h0080, 16'h0050, 16'h0357, 16'h1040);
        pulse_start();
        wait_done("t2");
        chk("t2_tile_cnt", 32'(tile_cnt), 32'd4);
        push_tile(16'h0520, 16'h9240, 16'h0120);
        push_tile(16'h0520, 16'h9241, 16'h0110);
        push_tile(16'h0520, 16'h9242, 16'h0100);
        push_tile(16'h0A40, 16'h8357, 16'h0080);
        push_fill();
        check_line("t2");
        code_mask = 4'hF;
        code_offset = 4'h0;

        // Clipping at XMAX and XMIN edges
        vrender = 9'h055;
        clear_frame(vrender);
        set_obj(255, 16'h01B0, 16'h0050, 16'h0000, 16'h0100);
        set_obj(254, 16'h0030, 16'h0050, 16'h0001, 16'h0000);
        set_obj(253, 16'h0031, 16'h0050, 16'h0002, 16'h0000);
        pulse_start();
        wait_done("t3");
        chk("t3_tile_cnt", 32'(tile_cnt), 32'd2);
        push_tile(16'h0500, 16'h0000, 16'h01B0);
        push_tile(16'h0500, 16'h0002, 16'h0031);
        push_fill();
        check_line("t3");

        // Duplicate objects
        vrender = 9'h055;
        clear_frame(vrender);
        set_obj(255, 16'h0100, 16'h0050, 16'h1230, 16'h0000);
        set_obj(254, 16'h0100, 16'h0050, 16'h1230, 16'h0000);
        pulse_start();
        wait_done("t4");
        repeat (60) @(negedge clk);
        chk("t4_tile_cnt_dup", 32'(tile_cnt), 32'd1);
        chk("t4_tile_cnt_nodup", 32'(tile_cnt_nd), 32'd2);
        chk("t4_busy_nodup", 32'(busy_nd), 32'd0);
        push_tile(16'h0500, 16'h1230, 16'h0100);
        push_fill();
        check_line("t4");

        // Overflow: 130 distinct tiles into 128 slots
        vrender = 9'h055;
        clear_frame(vrender);
        for (int k = 255; k >= 126; k--) set_obj(k, 16'h0100, 16'h0050, 16'(k), 16'h0000);
        pulse_start();
        wait_done("t5");
        chk("t5_tile_cnt", 32'(tile_cnt), 32'd128);
        chk("t5_overflow", 32'(overflow), 32'd1);
        for (int k = 255; k >= 128; k--) push_tile(16'h0500, 16'(k), 16'h0100);
        check_line("t5");

        // End marker, with an abort-restart partway through
        vrender = 9'h055;
        clear_frame(vrender);
        set_obj(255, 16'h0100, 16'h0050, 16'h0042, 16'h0000);
        set_obj(254, 16'h0100, 16'h0050, 16'h0000, 16'hFF00);
        set_obj(253, 16'h0100, 16'h0050, 16'h0043, 16'h0000);
        pulse_start();
        repeat (20) @(negedge clk);
        chk("t6_busy_mid", 32'(busy), 32'd1);
        pulse_start();
        chk("t6_overflow_cleared", 32'(overflow), 32'd0);
        wait_done("t6");
        chk("t6_tile_cnt", 32'(tile_cnt), 32'd1);
        push_tile(16'h0500, 16'h0042, 16'h0100);
        push_fill();
        check_line("t6");

        // Asynchronous reset mid-build
        pulse_start();
        repeat (30) @(negedge clk);
        chk("t7_busy_before", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_frame_addr", 32'(frame_addr), 32'h3FF);
        chk("t7_tile_cnt", 32'(tile_cnt), 32'd0);
        chk("t7_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t7_stays_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
